fir_ss_feeder: RTL

- Upstream AXI-Stream input stage for the fir core; drives its ss_tvalid/ss_tdata/ss_tlast channel.
- Accepts raw samples from a producer (DMA or test source) and buffers them in a small FWFT FIFO.
- Counts samples against a programmed frame length and generates ss_tlast on the final sample, independent of the producer's own tlast.
- Reports level, progress, done and a sticky tlast-mismatch flag.

---
 rtl/fir_ss_feeder.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/fir_ss_feeder.sv
// Upstream AXI-Stream stage for the fir core: buffers producer samples in a
// first-word-fall-through FIFO and marks the frame's final sample with ss_tlast.
module fir_ss_feeder #(
  parameter int pDATA_WIDTH = 32,
  parameter int pDEPTH      = 8,
  parameter int pCNT_WIDTH  = 32
) (
  input  logic                          axis_clk,
  input  logic                          axis_rst,
  input  logic                          start,
  input  logic [pCNT_WIDTH-1:0]         data_length,
  input  logic                          in_tvalid,
  input  logic signed [pDATA_WIDTH-1:0] in_tdata,
  input  logic                          in_tlast,
  output logic                          in_tready,
  output logic                          ss_tvalid,
  output logic signed [pDATA_WIDTH-1:0] ss_tdata,
  output logic                          ss_tlast,
  input  logic                          ss_tready,
  output logic                          busy,
  output logic                          done,
  output logic                          tlast_err,
  output logic                          len_err,
  output logic [$clog2(pDEPTH):0]       fifo_level,
  output logic [pCNT_WIDTH-1:0]         out_cnt
);

  localparam int AW = $clog2(pDEPTH);
  localparam logic [AW-1:0]         PTR_ONE  = AW'(1);
  localparam logic [AW:0]           LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]           LVL_FULL = (AW+1)'(pDEPTH);
  localparam logic [pCNT_WIDTH-1:0] CNT_ONE  = pCNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic signed [pDATA_WIDTH-1:0] r_mem_data [pDEPTH];
  logic                          r_mem_last [pDEPTH];
  logic [AW-1:0]                 r_wr_ptr;
  logic [AW-1:0]                 r_rd_ptr;
  logic [AW:0]                   r_level;
  logic [pCNT_WIDTH-1:0]         r_len_q;
  logic [pCNT_WIDTH-1:0]         r_in_cnt;
  logic [pCNT_WIDTH-1:0]         r_out_cnt;
  logic                          r_tlast_err;
  logic                          r_len_err;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_push_last;
  logic w_pop_last;
  logic w_start_ok;
  logic w_start_zero;
  logic w_in_tready;
  logic w_busy;
  logic w_done;

  assign w_full       = (r_level == LVL_FULL);
  assign w_empty      = (r_level == '0);
  assign w_start_ok   = (r_state == S_IDLE) && start && (data_length != '0);
  assign w_start_zero = (r_state == S_IDLE) && start && (data_length == '0);
  assign w_push       = in_tvalid && w_in_tready;
  assign w_pop        = !w_empty && ss_tready;
  // The frame's last sample is decided by our own count, not the producer's tlast.
  assign w_push_last  = ((r_in_cnt + CNT_ONE) == r_len_q);
  assign w_pop_last   = w_pop && r_mem_last[r_rd_ptr];

  // ---- state register ----
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_state_nxt = S_RUN;
      S_RUN:   if (w_pop_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---- state outputs ----
  always_comb begin
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_in_tready = 1'b0;
    case (r_state)
      S_RUN: begin
        w_busy      = 1'b1;
        w_in_tready = !w_full && (r_in_cnt < r_len_q);
      end
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  // ---- FIFO storage (data path, not reset) ----
  always_ff @(posedge axis_clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= in_tdata;
      r_mem_last[r_wr_ptr] <= w_push_last;
    end
  end

  // ---- FIFO pointers and occupancy ----
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // ---- frame counters and status flags ----
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      r_len_q     <= '0;
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_tlast_err <= 1'b0;
      r_len_err   <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_len_q     <= data_length;
        r_in_cnt    <= '0;
        r_out_cnt   <= '0;
        r_tlast_err <= 1'b0;
        r_len_err   <= 1'b0;
      end else begin
        if (w_start_zero) r_len_err <= 1'b1;
        if (w_push) begin
          r_in_cnt <= r_in_cnt + CNT_ONE;
          if (in_tlast != w_push_last) r_tlast_err <= 1'b1;
        end
        if (w_pop) r_out_cnt <= r_out_cnt + CNT_ONE;
      end
    end
  end

  assign in_tready  = w_in_tready;
  assign ss_tvalid  = !w_empty;
  assign ss_tdata   = w_empty ? '0 : r_mem_data[r_rd_ptr];
  assign ss_tlast   = !w_empty && r_mem_last[r_rd_ptr];
  assign busy       = w_busy;
  assign done       = w_done;
  assign tlast_err  = r_tlast_err;
  assign len_err    = r_len_err;
  assign fifo_level = r_level;
  assign out_cnt    = r_out_cnt;

endmodule
